// File: rtl/sntc_ldpc_pkg.sv
// Shared types and width helpers for the LDPC syndrome controller slice.
package sntc_ldpc_pkg;

  typedef enum logic [2:0] {IDLE, CLR, WAIT, EVAL, UPD, DONE} syn_ctrl_st_t;

  function automatic int iter_width(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

  function automatic int wt_width(input int mm);
    return $clog2(mm + 1);
  endfunction

endpackage

// File: rtl/sntc_popcount.sv
// Combinational popcount of the syndrome vector.
module sntc_popcount #(
  parameter int W  = 168,
  parameter int OW = 8
) (
  input  logic [W-1:0]  i_vec,
  output logic [OW-1:0] o_cnt
);

  // Written as a linear sum; synthesis rebalances it into an adder tree.
  always_comb begin
    o_cnt = '0;
    for (int i = 0; i < W; i++) begin
      o_cnt = o_cnt + OW'(i_vec[i]);
    end
  end

endmodule

// File: rtl/sntc_ldpc_syndrome_ctrl.sv
// Sequencer around the LDPC syndrome wrapper.
// It also drives the external bit-flip update engine until the syndrome is zero or the budget runs out.
module sntc_ldpc_syndrome_ctrl
  import sntc_ldpc_pkg::*;
#(
  parameter int NN       = 'h0d0,
  parameter int MM       = 'h0a8,
  parameter int SYN_LAT  = 1,
  parameter int MAX_ITER = 16,
  parameter int ITW      = iter_width(MAX_ITER),
  parameter int SUM_MM   = wt_width(MM)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NN-1:0]     in_cw,
  input  logic [ITW-1:0]    cfg_max_iter,
  output logic [NN-1:0]     y_nr_out,
  output logic              syn_clr,
  input  logic [MM-1:0]     syn_in,
  input  logic              cword_ok,
  output logic              upd_req,
  input  logic              upd_ack,
  input  logic [NN-1:0]     upd_cw,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NN-1:0]     out_cw,
  output logic              out_pass,
  output logic [ITW-1:0]    out_iter,
  output logic [SUM_MM-1:0] out_syn_wt
);

  localparam int LATW = (SYN_LAT > 1) ? $clog2(SYN_LAT) : 1;

  syn_ctrl_st_t      r_state;
  logic [LATW-1:0]   r_wait;
  logic [ITW-1:0]    r_budget;
  logic [ITW-1:0]    r_iter;
  logic [NN-1:0]     r_word;
  logic              r_in_ready;
  logic              r_syn_clr;
  logic              r_upd_req;
  logic              r_out_valid;
  logic              r_pass;
  logic [SUM_MM-1:0] r_wt;

  logic [SUM_MM-1:0] w_wt;
  logic [ITW-1:0]    w_budget;

  sntc_popcount #(.W(MM), .OW(SUM_MM)) u_popcount (
    .i_vec (syn_in),
    .o_cnt (w_wt)
  );

  assign w_budget = (cfg_max_iter > ITW'(MAX_ITER)) ? ITW'(MAX_ITER) : cfg_max_iter;

  // Iteration count can only grow from UPD, which is entered only while iter < budget,
  // so the counter saturates at the budget without an explicit clamp.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_budget    <= '0;
      r_iter      <= '0;
      r_word      <= '0;
      r_in_ready  <= 1'b1;
      r_syn_clr   <= 1'b0;
      r_upd_req   <= 1'b0;
      r_out_valid <= 1'b0;
      r_pass      <= 1'b0;
      r_wt        <= '0;
    end else begin
      r_syn_clr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_word     <= in_cw;
            r_budget   <= w_budget;
            r_iter     <= '0;
            r_in_ready <= 1'b0;
            r_syn_clr  <= 1'b1;
            r_state    <= CLR;
          end
        end
        CLR: begin
          r_wait  <= LATW'(SYN_LAT - 1);
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_wait == '0) r_state <= EVAL;
          else              r_wait  <= r_wait - LATW'(1);
        end
        EVAL: begin
          r_wt <= cword_ok ? '0 : w_wt;
          if (cword_ok || (r_iter == r_budget)) begin
            r_pass      <= cword_ok;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_upd_req <= 1'b1;
            r_state   <= UPD;
          end
        end
        UPD: begin
          if (upd_ack) begin
            r_word    <= upd_cw;
            r_iter    <= r_iter + ITW'(1);
            r_upd_req <= 1'b0;
            r_syn_clr <= 1'b1;
            r_state   <= CLR;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_upd_req   <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign y_nr_out   = r_word;
  assign syn_clr    = r_syn_clr;
  assign upd_req    = r_upd_req;
  assign out_valid  = r_out_valid;
  assign out_cw     = r_word;
  assign out_pass   = r_pass;
  assign out_iter   = r_iter;
  assign out_syn_wt = r_wt;

endmodule

// File: tb/tb_sntc_ldpc_syndrome_ctrl.sv
// Bench for sntc_ldpc_syndrome_ctrl with a behavioural syndrome wrapper (SYN_LAT=1) and bit-flipper.
// Expected results come from a reference decoder loop and sit in a scoreboard queue.
module tb_sntc_ldpc_syndrome_ctrl;

  localparam int NN       = 208;
  localparam int MM       = 168;
  localparam int SYN_LAT  = 1;
  localparam int MAX_ITER = 16;
  localparam int ITW      = 5;
  localparam int SUM_MM   = 8;

  typedef struct {
    logic [NN-1:0] cw;
    logic          pass;
    int            iter;
    int            wt;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_valid;
  logic              in_ready;
  logic [NN-1:0]     in_cw;
  logic [ITW-1:0]    cfg_max_iter;
  logic [NN-1:0]     y_nr_out;
  logic              syn_clr;
  logic [MM-1:0]     syn_in;
  logic              cword_ok;
  logic              upd_req;
  logic              upd_ack;
  logic [NN-1:0]     upd_cw;
  logic              out_valid;
  logic              out_ready;
  logic [NN-1:0]     out_cw;
  logic              out_pass;
  logic [ITW-1:0]    out_iter;
  logic [SUM_MM-1:0] out_syn_wt;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int clrCount = 0;
  int hsCount = 0;
  int reqCount = 0;
  int acceptCyc, clrAtAccept, hsAtAccept, reqAtAccept;
  int flipMode = 0;
  int flipDelay = 3;
  int lateAckCyc = -1;
  bit flipEnable = 1'b1;
  logic [MM-1:0] synReg;
  exp_t q[$];

  always #5 clk = ~clk;

  sntc_ldpc_syndrome_ctrl #(
    .NN(NN), .MM(MM), .SYN_LAT(SYN_LAT), .MAX_ITER(MAX_ITER), .ITW(ITW), .SUM_MM(SUM_MM)
  ) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw), .cfg_max_iter(cfg_max_iter),
    .y_nr_out(y_nr_out), .syn_clr(syn_clr), .syn_in(syn_in), .cword_ok(cword_ok),
    .upd_req(upd_req), .upd_ack(upd_ack), .upd_cw(upd_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_cw(out_cw),
    .out_pass(out_pass), .out_iter(out_iter), .out_syn_wt(out_syn_wt)
  );

  // Toy parity-check matrix: row r checks bit r, and rows below NN-MM also check bit r+MM.
  function automatic logic [MM-1:0] hMul(input logic [NN-1:0] w);
    logic [MM-1:0] s;
    for (int r = 0; r < MM; r++) begin
      s[r] = w[r];
      if (r < NN - MM) s[r] = s[r] ^ w[r + MM];
    end
    return s;
  endfunction

  // Mode 0 flips the own bit of each failing row (converges); mode 1 flips the neighbour (never does).
  function automatic logic [NN-1:0] flipWord(input logic [NN-1:0] w, input int mode);
    logic [MM-1:0] s;
    logic [NN-1:0] nw;
    int b;
    s = hMul(w);
    nw = w;
    for (int r = 0; r < MM; r++) begin
      if (s[r]) begin
        b = (mode == 0) ? r : (r + 1) % MM;
        nw[b] = ~nw[b];
      end
    end
    return nw;
  endfunction

  function automatic exp_t refModel(input logic [NN-1:0] cw, input int cfg, input int mode);
    exp_t e;
    logic [MM-1:0] s;
    int budget;
    budget = (cfg > MAX_ITER) ? MAX_ITER : cfg;
    e.cw = cw; e.iter = 0; e.pass = 1'b0; e.wt = 0;
    for (int k = 0; k <= MAX_ITER; k++) begin
      s = hMul(e.cw);
      if (s == '0) begin
        e.pass = 1'b1;
        break;
      end
      if (e.iter == budget) begin
        e.wt = $countones(s);
        break;
      end
      e.cw = flipWord(e.cw, mode);
      e.iter++;
    end
    return e;
  endfunction

  // Behavioural syndrome wrapper: recomputes on clr, result settles one cycle later.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) synReg <= '0;
    else if (syn_clr) synReg <= hMul(y_nr_out);
  end
  assign syn_in   = synReg;
  assign cword_ok = (synReg == '0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (syn_clr) clrCount <= clrCount + 1;
    if (upd_req && upd_ack) hsCount <= hsCount + 1;
    if (upd_req) reqCount <= reqCount + 1;
  end

  // Update engine: acks flipDelay cycles after the request, or injects a stray ack on demand.
  initial begin
    int age;
    age = 0;
    upd_ack = 1'b0;
    upd_cw = '0;
    forever begin
      @(posedge clk);
      #1;
      upd_ack = 1'b0;
      if (cyc == lateAckCyc) begin
        upd_ack = 1'b1;
        upd_cw = '1;
      end else if (flipEnable && rstn && upd_req) begin
        if (age == flipDelay) begin
          upd_ack = 1'b1;
          upd_cw = flipWord(y_nr_out, flipMode);
          age = 0;
        end else begin
          age++;
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_flags"}, 256'({in_ready, out_valid, syn_clr, upd_req, out_pass}), 256'(5'b10000));
    check({tag, "_word"}, 256'(y_nr_out), 256'(0));
    check({tag, "_cnt"}, 256'({out_iter, out_syn_wt}), 256'(0));
  endtask

  task automatic applyStimulus(input logic [NN-1:0] cw, input int cfg, input int mode);
    flipMode = mode;
    for (int k = 0; k < 200 && in_ready !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    check("accept_ready", 256'(in_ready), 256'(1));
    in_valid = 1'b1;
    in_cw = cw;
    cfg_max_iter = ITW'(cfg);
    q.push_back(refModel(cw, cfg, mode));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acceptCyc = cyc;
    clrAtAccept = clrCount;
    hsAtAccept = hsCount;
    reqAtAccept = reqCount;
  endtask

  task automatic checkOutput(input string tag, input int stall, input int expLat);
    exp_t e;
    logic [NN-1:0] snapCw;
    logic [ITW+SUM_MM:0] snapMeta;
    bit stable;
    for (int k = 0; k < 1000 && out_valid !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_out_valid"}, 256'(out_valid), 256'(1));
    if (expLat > 0) check({tag, "_latency"}, 256'(cyc - acceptCyc + 1), 256'(expLat));
    e = q.pop_front();
    check({tag, "_cw"}, 256'(out_cw), 256'(e.cw));
    check({tag, "_pass"}, 256'(out_pass), 256'(e.pass));
    check({tag, "_iter"}, 256'(out_iter), 256'(e.iter));
    check({tag, "_syn_wt"}, 256'(out_syn_wt), 256'(e.wt));
    if (stall > 0) begin
      snapCw = out_cw;
      snapMeta = {out_pass, out_iter, out_syn_wt};
      stable = 1'b1;
      for (int k = 0; k < stall; k++) begin
        @(posedge clk);
        #1;
        if (out_cw !== snapCw || {out_pass, out_iter, out_syn_wt} !== snapMeta ||
            out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
      end
      check({tag, "_stall_stable"}, 256'(stable), 256'(1));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_done_exit"}, 256'({in_ready, out_valid}), 256'(2'b10));
  endtask

  initial begin
    logic [NN-1:0] w;
    rstn = 1'b0;
    in_valid = 1'b0;
    in_cw = '0;
    cfg_max_iter = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] clean codeword, check-and-accept latency");
    applyStimulus('0, 4, 0);
    checkOutput("clean", 0, 3 + SYN_LAT);
    check("clean_clr_pulses", 256'(clrCount - clrAtAccept), 256'(1));
    check("clean_no_upd_req", 256'(reqCount - reqAtAccept), 256'(0));

    $display("[TB] single bit error fixed in one update");
    w = '0; w[5] = 1'b1;
    applyStimulus(w, 4, 0);
    checkOutput("fix1", 0, 0);
    check("fix1_iter_const", 256'(out_iter), 256'(1));
    check("fix1_clr_pulses", 256'(clrCount - clrAtAccept), 256'(2));
    check("fix1_handshakes", 256'(hsCount - hsAtAccept), 256'(1));

    $display("[TB] uncorrectable word, budget of 2");
    w = '0; w[5] = 1'b1;
    applyStimulus(w, 2, 1);
    checkOutput("uncorr", 0, 0);
    check("uncorr_handshakes", 256'(hsCount - hsAtAccept), 256'(2));
    check("uncorr_wt_const", 256'(out_syn_wt), 256'(2));

    $display("[TB] budget 31 clamps to MAX_ITER");
    w = '0; w[10] = 1'b1;
    applyStimulus(w, 31, 1);
    checkOutput("clamp", 0, 0);
    check("clamp_iter_const", 256'({out_pass, out_iter}), 256'({1'b0, 5'd16}));

    $display("[TB] consumer stalls 10 cycles in DONE");
    w = '0; w[100] = 1'b1; w[180] = 1'b1;
    applyStimulus(w, 3, 0);
    checkOutput("stall", 10, 0);

    $display("[TB] reset during UPD with a late ack");
    flipEnable = 1'b0;
    w = '0; w[7] = 1'b1;
    applyStimulus(w, 4, 0);
    void'(q.pop_back());
    for (int k = 0; k < 50 && upd_req !== 1'b1; k++) begin
      @(posedge clk);
      #1;
    end
    check("rst_upd_req_seen", 256'(upd_req), 256'(1));
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #2;
    checkResetOutputs("midreset");
    @(negedge clk);
    rstn = 1'b1;
    lateAckCyc = cyc + 1;
    repeat (3) @(posedge clk);
    #1;
    check("late_ack_ignored", 256'({in_ready, upd_req, out_valid}), 256'(3'b100));
    check("late_ack_word", 256'(y_nr_out), 256'(0));
    flipEnable = 1'b1;
    w = '0; w[9] = 1'b1;
    applyStimulus(w, 4, 0);
    checkOutput("post_reset", 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
